// File: rtl/any1_pkg.sv
// Shared types and constants for the branch-history-table update scheduler.
package any1_pkg;

   localparam int BHT_IDX_W  = 9;
   localparam int UPDQ_DEPTH = 4;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bht_state_e;

   typedef struct packed {
      logic [31:0] ip;
      logic        takb;
   } bht_upd_t;

endpackage

// File: rtl/any1_bht_updq.sv
// Two-write / one-read update queue.
// Slot 1 lands right after slot 0, so commit order is kept.
module any1_bht_updq
   import any1_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     clr_i,
   input  logic     push0_i,
   input  logic     push1_i,
   input  bht_upd_t d0_i,
   input  bht_upd_t d1_i,
   input  logic     pop_i,
   output bht_upd_t head_o,
   output logic [2:0] count_o
);

   localparam int PTR_W = $clog2(UPDQ_DEPTH);

   bht_upd_t            mem_q [UPDQ_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [2:0]          count_q, count_d;
   logic [PTR_W-1:0]    wa1;
   logic [PTR_W-1:0]    npush;

   // A lone slot-1 push takes the write pointer itself, keeping the queue compact.
   assign wa1   = push0_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
   assign npush = PTR_W'(push0_i) + PTR_W'(push1_i);

   always_comb begin
      wr_ptr_d = wr_ptr_q + npush;
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + 3'(npush) - 3'(pop_i);
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_i) begin
         if (push0_i) mem_q[wr_ptr_q] <= d0_i;
         if (push1_i) mem_q[wa1]      <= d1_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/any1_bht_update_sched.sv
// Sequences BHT init sweeps and queues retired-branch outcomes
// so the predictor sees at most one update per cycle.
module any1_bht_update_sched
   import any1_pkg::*;
#(
   parameter int         BHT_DEPTH = 512,
   parameter logic [1:0] INIT_VAL  = 2'd3
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         init_req,
   input  logic                         c0_branch,
   input  logic                         c1_branch,
   input  logic [31:0]                  c0_ip,
   input  logic [31:0]                  c1_ip,
   input  logic                         c0_takb,
   input  logic                         c1_takb,
   output logic                         stall,
   output logic                         upd_valid,
   output logic [31:0]                  upd_ip,
   output logic                         upd_takb,
   output logic                         init_wr,
   output logic [$clog2(BHT_DEPTH)-1:0] init_addr,
   output logic [1:0]                   init_data,
   output logic                         busy
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(BHT_DEPTH - 1);

   bht_state_e       state_q, state_d;
   logic [IDX_W-1:0] addr_q, addr_d;
   logic             accept, push0, push1, pop;
   bht_upd_t         head;
   logic [2:0]       count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         INIT: begin
            if (addr_q == LAST_ADDR) begin
               state_d = RUN;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + IDX_W'(1);
            end
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
      if (init_req) begin
         state_d = INIT;
         addr_d  = '0;
      end
   end

   // stall depends only on registered state, never on the commit inputs.
   always_comb begin
      busy      = (state_q == INIT);
      init_wr   = (state_q == INIT);
      init_addr = addr_q;
      init_data = INIT_VAL;
      stall     = (state_q == INIT) || (count >= 3'd3);
      pop       = (state_q == RUN) && en && (count != 3'd0);
      upd_valid = pop;
      upd_ip    = head.ip;
      upd_takb  = head.takb;
   end

   // A taken slot-0 branch redirects fetch, so slot 1 is off-path.
   assign accept = (state_q == RUN) && !stall;
   assign push0  = accept && c0_branch;
   assign push1  = accept && c1_branch && !(c0_branch && c0_takb);

   any1_bht_updq u_q (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (init_req),
      .push0_i (push0),
      .push1_i (push1),
      .d0_i    ('{ip: c0_ip, takb: c0_takb}),
      .d1_i    ('{ip: c1_ip, takb: c1_takb}),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

endmodule
